// File: rtl/hex_digit_counter_if.sv
// rtl/hex_digit_counter_if.sv - switch/button inputs and display outputs of the hex digit counter
//
// Signals:
//   i_run       switch level, 1 = counting enabled
//   i_dir       switch level, 0 = up, 1 = down
//   i_dec_mode  switch level, 1 = decimal digits, 0 = hex digits
//   i_clear_n   push button, active-low, press clears the count
//   o24_digits  six 4-bit digit values, digit k at [4k+3:4k]
//   o6_dots     active-low dots, bit 0 is the heartbeat
//   o_tick      one-cycle pulse per count step
//   o_wrap      one-cycle pulse when the whole counter wraps
// Modports: master drives the controls and watches the display, slave is the counter.

interface hex_digit_counter_if;
   logic        i_run;
   logic        i_dir;
   logic        i_dec_mode;
   logic        i_clear_n;
   logic [23:0] o24_digits;
   logic [5:0]  o6_dots;
   logic        o_tick;
   logic        o_wrap;

   modport master (
      output i_run,
      output i_dir,
      output i_dec_mode,
      output i_clear_n,
      input  o24_digits,
      input  o6_dots,
      input  o_tick,
      input  o_wrap
   );

   modport slave (
      input  i_run,
      input  i_dir,
      input  i_dec_mode,
      input  i_clear_n,
      output o24_digits,
      output o6_dots,
      output o_tick,
      output o_wrap
   );
endinterface

// File: rtl/hex_digit_counter.sv
// rtl/hex_digit_counter.sv - six-digit hex/decimal up/down counter for the hexSegment displays
//
// Ports:
//   i_clk    board clock, single clock domain
//   i_rst_n  asynchronous active-low reset
//   disp     hex_digit_counter_if.slave: asynchronous switch/button inputs in,
//            registered digits, dots, tick and wrap pulses out
// Parameters:
//   CLK_HZ   input clock frequency
//   TICK_HZ  count steps per second; CLK_HZ/TICK_HZ must be an integer >= 2

module hex_digit_counter #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 10
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   hex_digit_counter_if.slave disp
);

   localparam int            DIV        = CLK_HZ / TICK_HZ;
   localparam int            PW         = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   // Two-flop synchronisers
   logic run_meta_q,  run_s_q;
   logic dir_meta_q,  dir_s_q;
   logic mode_meta_q, mode_s_q;
   logic clr_meta_q,  clr_s_q;

   // Edge-detect history of the synchronised button and mode switch
   logic clr_prev_q;
   logic mode_prev_q;

   // Counter state
   logic [PW-1:0] presc_q,  presc_d;
   logic [23:0]   digits_q, digits_d;
   logic          dot0_q,   dot0_d;
   logic          tick_q,   tick_d;
   logic          wrap_q,   wrap_d;

   logic          clr_evt;
   logic          mode_evt;
   logic          step;
   logic [3:0]    digit_max;
   logic [23:0]   stepped;
   logic          carry;

   assign clr_evt   = clr_prev_q & ~clr_s_q;
   assign mode_evt  = mode_s_q ^ mode_prev_q;
   assign step      = run_s_q & (presc_q == PRESC_LAST);
   assign digit_max = mode_s_q ? 4'd9 : 4'd15;

   // Ripple the +1/-1 through the digits; carry doubles as borrow when
   // counting down and is still set after digit 5 only on a full wrap.
   always_comb begin
      stepped = digits_q;
      carry   = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (carry) begin
            if (!dir_s_q) begin
               if (digits_q[4*k +: 4] == digit_max) begin
                  stepped[4*k +: 4] = 4'h0;
               end else begin
                  stepped[4*k +: 4] = digits_q[4*k +: 4] + 4'h1;
                  carry             = 1'b0;
               end
            end else begin
               if (digits_q[4*k +: 4] == 4'h0) begin
                  stepped[4*k +: 4] = digit_max;
               end else begin
                  stepped[4*k +: 4] = digits_q[4*k +: 4] - 4'h1;
                  carry             = 1'b0;
               end
            end
         end
      end
   end

   // Clear or mode change wins over a coincident step, which is dropped
   // entirely (no tick, no wrap, no heartbeat toggle).
   always_comb begin
      presc_d  = presc_q;
      digits_d = digits_q;
      dot0_d   = dot0_q;
      tick_d   = 1'b0;
      wrap_d   = 1'b0;
      if (clr_evt || mode_evt) begin
         presc_d  = '0;
         digits_d = '0;
         dot0_d   = 1'b1;
      end else if (step) begin
         presc_d  = '0;
         digits_d = stepped;
         dot0_d   = ~dot0_q;
         tick_d   = 1'b1;
         wrap_d   = carry;
      end else if (run_s_q) begin
         presc_d  = presc_q + PW'(1);
      end
   end

   // The clear path resets high so that leaving reset never looks like a press.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run_meta_q  <= 1'b0;
         run_s_q     <= 1'b0;
         dir_meta_q  <= 1'b0;
         dir_s_q     <= 1'b0;
         mode_meta_q <= 1'b0;
         mode_s_q    <= 1'b0;
         clr_meta_q  <= 1'b1;
         clr_s_q     <= 1'b1;
         clr_prev_q  <= 1'b1;
         mode_prev_q <= 1'b0;
      end else begin
         run_meta_q  <= disp.i_run;
         run_s_q     <= run_meta_q;
         dir_meta_q  <= disp.i_dir;
         dir_s_q     <= dir_meta_q;
         mode_meta_q <= disp.i_dec_mode;
         mode_s_q    <= mode_meta_q;
         clr_meta_q  <= disp.i_clear_n;
         clr_s_q     <= clr_meta_q;
         clr_prev_q  <= clr_s_q;
         mode_prev_q <= mode_s_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         presc_q  <= '0;
         digits_q <= '0;
         dot0_q   <= 1'b1;
         tick_q   <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         digits_q <= digits_d;
         dot0_q   <= dot0_d;
         tick_q   <= tick_d;
         wrap_q   <= wrap_d;
      end
   end

   assign disp.o24_digits = digits_q;
   assign disp.o6_dots    = {5'b11111, dot0_q};
   assign disp.o_tick     = tick_q;
   assign disp.o_wrap     = wrap_q;

endmodule

// File: tb/tb_hex_digit_counter.sv
// tb/tb_hex_digit_counter.sv - self-checking bench for hex_digit_counter with a value-level reference model

module tb_hex_digit_counter;

   localparam int DIV = 10;

   logic clk = 1'b0;
   logic rst_n;

   hex_digit_counter_if dif ();

   hex_digit_counter #(
      .CLK_HZ  (100),
      .TICK_HZ (10)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .disp    (dif)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model: the count is one integer modulo base**6.
   int m_val, m_presc, m_base;
   bit m_dot, m_tick, m_wrap;
   bit s1_run, s1_dir, s1_mode, s1_clr;
   bit s2_run, s2_dir, s2_mode, s2_clr;
   bit p_clr, p_mode;

   function automatic int ipow(int b, int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = r * b;
      return r;
   endfunction

   function automatic logic [23:0] to_digits(int v, int b);
      logic [23:0] r;
      int t = v;
      for (int k = 0; k < 6; k++) begin
         r[4*k +: 4] = 4'(t % b);
         t = t / b;
      end
      return r;
   endfunction

   task automatic model_reset();
      s1_run = 0; s1_dir = 0; s1_mode = 0; s1_clr = 1;
      s2_run = 0; s2_dir = 0; s2_mode = 0; s2_clr = 1;
      p_clr = 1; p_mode = 0;
      m_val = 0; m_presc = 0; m_base = 16;
      m_dot = 1; m_tick = 0; m_wrap = 0;
   endtask

   // Inputs reach the counter logic two edges after being sampled.
   task automatic model_edge();
      int n;
      if (!rst_n) begin
         model_reset();
      end else begin
         m_base = s2_mode ? 10 : 16;
         n = ipow(m_base, 6);
         m_tick = 0;
         m_wrap = 0;
         if ((p_clr && !s2_clr) || (s2_mode != p_mode)) begin
            m_val = 0; m_presc = 0; m_dot = 1;
         end else if (s2_run && m_presc == DIV - 1) begin
            m_presc = 0;
            m_tick  = 1;
            m_dot   = !m_dot;
            if (!s2_dir) begin
               m_wrap = (m_val == n - 1);
               m_val  = (m_val + 1) % n;
            end else begin
               m_wrap = (m_val == 0);
               m_val  = (m_val + n - 1) % n;
            end
         end else if (s2_run) begin
            m_presc++;
         end
         p_clr  = s2_clr;
         p_mode = s2_mode;
         s2_run = s1_run; s2_dir = s1_dir; s2_mode = s1_mode; s2_clr = s1_clr;
         s1_run = dif.i_run; s1_dir = dif.i_dir; s1_mode = dif.i_dec_mode; s1_clr = dif.i_clear_n;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_eq("digits", 32'(dif.o24_digits), 32'(to_digits(m_val, m_base)));
      check_eq("dots",   32'(dif.o6_dots),    32'({5'b11111, m_dot}));
      check_eq("tick",   32'(dif.o_tick),     32'(m_tick));
      check_eq("wrap",   32'(dif.o_wrap),     32'(m_wrap));
   endtask

   task automatic wait_tick(output int n);
      bit seen = 0;
      n = 0;
      while (!seen && n < 40) begin
         cycle();
         n++;
         if (dif.o_tick) seen = 1;
      end
      check_eq("tick_seen", 32'(seen), 32'd1);
   endtask

   task automatic apply_reset(input bit run, input bit dir, input bit mode);
      rst_n = 0;
      model_reset();
      dif.i_run = run; dif.i_dir = dir; dif.i_dec_mode = mode; dif.i_clear_n = 1;
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      int   n;
      logic prev_dot;
      int   pause_ticks;

      // Reset and idle
      rst_n = 0;
      dif.i_run = 0; dif.i_dir = 0; dif.i_dec_mode = 0; dif.i_clear_n = 1;
      model_reset();
      repeat (3) @(negedge clk);
      check_eq("rst_digits", 32'(dif.o24_digits), 32'h0);
      check_eq("rst_dots",   32'(dif.o6_dots),    32'h3F);
      check_eq("rst_tick",   32'(dif.o_tick),     32'h0);
      check_eq("rst_wrap",   32'(dif.o_wrap),     32'h0);
      rst_n = 1;
      repeat (50) cycle();
      check_eq("idle_digits", 32'(dif.o24_digits), 32'h0);
      check_eq("idle_dots",   32'(dif.o6_dots),    32'h3F);

      // Hex up count
      dif.i_run = 1;
      wait_tick(n);
      prev_dot = dif.o6_dots[0];
      for (int i = 2; i <= 17; i++) begin
         wait_tick(n);
         check_eq("hex_period",  32'(n), 32'(DIV));
         check_eq("hex_dot_alt", 32'(dif.o6_dots[0]), 32'(!prev_dot));
         prev_dot = dif.o6_dots[0];
      end
      check_eq("hex_17", 32'(dif.o24_digits), 32'h000011);

      // Decimal carry, then down wrap and up wrap
      apply_reset(1, 0, 1);
      for (int i = 0; i < 10; i++) wait_tick(n);
      check_eq("dec_10", 32'(dif.o24_digits), 32'h000010);
      dif.i_dir = 1;
      dif.i_clear_n = 0;
      repeat (4) cycle();
      dif.i_clear_n = 1;
      wait_tick(n);
      check_eq("dec_down_digits", 32'(dif.o24_digits), 32'h999999);
      check_eq("dec_down_wrap",   32'(dif.o_wrap),     32'h1);
      dif.i_dir = 0;
      wait_tick(n);
      check_eq("dec_up_digits", 32'(dif.o24_digits), 32'h000000);
      check_eq("dec_up_wrap",   32'(dif.o_wrap),     32'h1);
      cycle();
      check_eq("wrap_one_cycle", 32'(dif.o_wrap), 32'h0);

      // Hex down wrap
      apply_reset(1, 1, 0);
      wait_tick(n);
      check_eq("hex_down1_digits", 32'(dif.o24_digits), 32'hFFFFFF);
      check_eq("hex_down1_wrap",   32'(dif.o_wrap),     32'h1);
      wait_tick(n);
      check_eq("hex_down2_digits", 32'(dif.o24_digits), 32'hFFFFFE);
      check_eq("hex_down2_wrap",   32'(dif.o_wrap),     32'h0);

      // Clear event landing on a step edge
      repeat (7) cycle();
      dif.i_clear_n = 0;
      repeat (3) cycle();
      check_eq("clr_step_digits", 32'(dif.o24_digits), 32'h0);
      check_eq("clr_step_tick",   32'(dif.o_tick),     32'h0);
      check_eq("clr_step_wrap",   32'(dif.o_wrap),     32'h0);
      check_eq("clr_step_dot",    32'(dif.o6_dots[0]), 32'h1);
      dif.i_clear_n = 1;
      wait_tick(n);
      check_eq("clr_next_period", 32'(n), 32'(DIV));
      check_eq("clr_next_digits", 32'(dif.o24_digits), 32'hFFFFFF);

      // Mode toggle mid-count clears on the third edge
      dif.i_dec_mode = 1;
      repeat (2) cycle();
      check_eq("mode_hold",  32'(dif.o24_digits), 32'hFFFFFF);
      cycle();
      check_eq("mode_clear", 32'(dif.o24_digits), 32'h0);

      // Pause mid-period and resume
      dif.i_dir = 0;
      wait_tick(n);
      repeat (3) cycle();
      dif.i_run = 0;
      pause_ticks = 0;
      repeat (20) begin
         cycle();
         if (dif.o_tick) pause_ticks++;
      end
      check_eq("pause_ticks", 32'(pause_ticks), 32'h0);
      check_eq("pause_digits", 32'(dif.o24_digits), 32'h000001);
      dif.i_run = 1;
      wait_tick(n);
      check_eq("resume_remaining", 32'(n), 32'd7);
      check_eq("resume_digits", 32'(dif.o24_digits), 32'h000002);

      // Asynchronous reset between clock edges
      repeat (4) cycle();
      #2;
      rst_n = 0;
      model_reset();
      #1;
      check_eq("async_digits", 32'(dif.o24_digits), 32'h0);
      check_eq("async_dots",   32'(dif.o6_dots),    32'h3F);
      check_eq("async_tick",   32'(dif.o_tick),     32'h0);
      check_eq("async_wrap",   32'(dif.o_wrap),     32'h0);
      @(negedge clk);
      rst_n = 1;

      // Random switch and button activity against the model
      for (int i = 0; i < 2500; i++) begin
         cycle();
         if ($urandom_range(39, 0) == 0) dif.i_run = !dif.i_run;
         if ($urandom_range(29, 0) == 0) dif.i_dir = !dif.i_dir;
         if ($urandom_range(199, 0) == 0) dif.i_dec_mode = !dif.i_dec_mode;
         if (!dif.i_clear_n) begin
            if ($urandom_range(2, 0) == 0) dif.i_clear_n = 1;
         end else if ($urandom_range(149, 0) == 0) begin
            dif.i_clear_n = 0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
